// File: rtl/hilo_unit.sv
// ============================================================================
//  Module   : hilo_unit
//  Purpose  : EX-stage HI/LO register pair with MUL writeback, MTHI/MTLO and
//             two-cycle MADD/MSUB accumulation (enabled by `HILO_MADD_EN`).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hilo_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [63:0] result_mult,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        stall_req,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy
);

  localparam logic [2:0] c_op_mul  = 3'd1;
  localparam logic [2:0] c_op_mthi = 3'd2;
  localparam logic [2:0] c_op_mtlo = 3'd3;
`ifdef HILO_MADD_EN
  localparam logic [2:0] c_op_madd = 3'd4;
  localparam logic [2:0] c_op_msub = 3'd5;
`endif

  logic [31:0] r_hi;
  logic [31:0] r_lo;

`ifdef HILO_MADD_EN
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  state_t      r_state;
  logic [63:0] r_prod_q;
  logic        r_sub_q;
  logic [63:0] w_acc;

  // Modulo-2^64; sign was already resolved by the multiplier.
  assign w_acc = r_sub_q ? ({r_hi, r_lo} - r_prod_q) : ({r_hi, r_lo} + r_prod_q);

  assign stall_req = (r_state == ST_ACC) ||
                     ((r_state == ST_IDLE) && op_valid && !flush &&
                      ((op == c_op_madd) || (op == c_op_msub)));
  assign busy      = (r_state == ST_ACC);
`else
  assign stall_req = 1'b0;
  assign busy      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
`ifdef HILO_MADD_EN
      r_state  <= ST_IDLE;
      r_prod_q <= 64'd0;
      r_sub_q  <= 1'b0;
`endif
    end else if (flush) begin
      // Kills an in-flight accumulate without writing HI/LO.
`ifdef HILO_MADD_EN
      r_state <= ST_IDLE;
`endif
    end
`ifdef HILO_MADD_EN
    else if (r_state == ST_ACC) begin
      {r_hi, r_lo} <= w_acc;
      r_state      <= ST_IDLE;
    end
`endif
    else if (op_valid) begin
      case (op)
        c_op_mul:  {r_hi, r_lo} <= result_mult;
        c_op_mthi: r_hi <= wdata;
        c_op_mtlo: r_lo <= wdata;
`ifdef HILO_MADD_EN
        c_op_madd, c_op_msub: begin
          r_prod_q <= result_mult;
          r_sub_q  <= (op == c_op_msub);
          r_state  <= ST_ACC;
        end
`endif
        default: ;
      endcase
    end
  end

  assign hi_o = r_hi;
  assign lo_o = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_hilo_unit.sv
// ============================================================================
//  Module   : tb_hilo_unit
//  Purpose  : Directed self-checking bench for hilo_unit; expectations adapt
//             to whether `HILO_MADD_EN` is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hilo_unit;

`ifdef HILO_MADD_EN
  localparam bit c_en = 1'b1;
`else
  localparam bit c_en = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [63:0] result_mult = 64'd0;
  logic [31:0] wdata = 32'd0;
  logic        flush = 1'b0;
  logic        stall_req;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy;

  int tests = 0;
  int fails = 0;

  hilo_unit dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .op          (op),
    .result_mult (result_mult),
    .wdata       (wdata),
    .flush       (flush),
    .stall_req   (stall_req),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [2:0] o, input logic [63:0] rm, input logic [31:0] wd);
    op_valid    = 1'b1;
    op          = o;
    result_mult = rm;
    wdata       = wd;
    #1;
  endtask

  task automatic idle_in;
    op_valid = 1'b0;
    op       = 3'd0;
  endtask

  task automatic load_hilo(input logic [63:0] v);
    present(3'd1, v, 32'd0);
    tick();
    idle_in();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    tests++; if (hi_o !== 32'd0) begin fails++; $display("FAIL reset_hi: got %h want %h", hi_o, 32'd0); end
    tests++; if (lo_o !== 32'd0) begin fails++; $display("FAIL reset_lo: got %h want %h", lo_o, 32'd0); end
    tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall_req); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_mul;
    present(3'd1, 64'h00000001_FFFFFFFE, 32'd0);
    tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL mul_stall: got %b want 0", stall_req); end
    tick();
    idle_in();
    tests++; if (hi_o !== 32'h00000001) begin fails++; $display("FAIL mul_hi: got %h want %h", hi_o, 32'h00000001); end
    tests++; if (lo_o !== 32'hFFFFFFFE) begin fails++; $display("FAIL mul_lo: got %h want %h", lo_o, 32'hFFFFFFFE); end
  endtask

  task automatic test_mthi_mtlo;
    present(3'd2, 64'd0, 32'hDEADBEEF);
    tick();
    tests++; if (lo_o !== 32'hFFFFFFFE) begin fails++; $display("FAIL mthi_lo_kept: got %h want %h", lo_o, 32'hFFFFFFFE); end
    present(3'd3, 64'd0, 32'h12345678);
    tick();
    idle_in();
    tests++; if (hi_o !== 32'hDEADBEEF) begin fails++; $display("FAIL mt_hi: got %h want %h", hi_o, 32'hDEADBEEF); end
    tests++; if (lo_o !== 32'h12345678) begin fails++; $display("FAIL mt_lo: got %h want %h", lo_o, 32'h12345678); end
    // Reserved codes must not write.
    present(3'd6, 64'h1111_1111_2222_2222, 32'hCAFEF00D);
    tick();
    present(3'd7, 64'h3333_3333_4444_4444, 32'hCAFEF00D);
    tick();
    idle_in();
    tests++; if ({hi_o, lo_o} !== 64'hDEADBEEF_12345678) begin fails++; $display("FAIL reserved_nop: got %h want %h", {hi_o, lo_o}, 64'hDEADBEEF_12345678); end
  endtask

  task automatic test_madd;
    load_hilo(64'h00000000_FFFFFFFF);
    present(3'd4, 64'd1, 32'd0);
    tests++; if (stall_req !== c_en) begin fails++; $display("FAIL madd_stall_c1: got %b want %b", stall_req, c_en); end
    tick();
    idle_in();
    result_mult = 64'hFFFF_0000_FFFF_0000;
    #1;
    tests++; if (stall_req !== c_en) begin fails++; $display("FAIL madd_stall_c2: got %b want %b", stall_req, c_en); end
    tests++; if (busy !== c_en) begin fails++; $display("FAIL madd_busy: got %b want %b", busy, c_en); end
    tests++; if ({hi_o, lo_o} !== 64'h00000000_FFFFFFFF) begin fails++; $display("FAIL madd_mid: got %h want %h", {hi_o, lo_o}, 64'h00000000_FFFFFFFF); end
    tick();
    tests++; if ({hi_o, lo_o} !== (c_en ? 64'h00000001_00000000 : 64'h00000000_FFFFFFFF)) begin
      fails++; $display("FAIL madd_result: got %h want %h", {hi_o, lo_o}, (c_en ? 64'h00000001_00000000 : 64'h00000000_FFFFFFFF)); end
    tests++; if (stall_req !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL madd_done: stall=%b busy=%b want 0 0", stall_req, busy); end
  endtask

  task automatic test_msub;
    load_hilo(64'd0);
    present(3'd5, 64'd1, 32'd0);
    tick();
    idle_in();
    tick();
    tests++; if ({hi_o, lo_o} !== (c_en ? 64'hFFFFFFFF_FFFFFFFF : 64'd0)) begin
      fails++; $display("FAIL msub_wrap: got %h want %h", {hi_o, lo_o}, (c_en ? 64'hFFFFFFFF_FFFFFFFF : 64'd0)); end
  endtask

  task automatic test_flush;
    load_hilo(64'h00000005_00000006);
    // Flush in IDLE: presented op is dropped.
    present(3'd1, 64'h9999_9999_9999_9999, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tests++; if ({hi_o, lo_o} !== 64'h00000005_00000006) begin fails++; $display("FAIL flush_idle: got %h want %h", {hi_o, lo_o}, 64'h00000005_00000006); end
    present(3'd4, 64'h10, 32'd0);
    flush = 1'b1;
    #1;
    tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL flush_idle_stall: got %b want 0", stall_req); end
    flush = 1'b0;
    #1;
    tick();
    idle_in();
    flush = 1'b1;
    #1;
    tests++; if (stall_req !== c_en) begin fails++; $display("FAIL flush_acc_stall: got %b want %b", stall_req, c_en); end
    tick();
    flush = 1'b0;
    #1;
    tests++; if ({hi_o, lo_o} !== 64'h00000005_00000006) begin fails++; $display("FAIL flush_acc_hilo: got %h want %h", {hi_o, lo_o}, 64'h00000005_00000006); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_acc_busy: got %b want 0", busy); end
    load_hilo(64'h00000007_00000008);
    tests++; if ({hi_o, lo_o} !== 64'h00000007_00000008) begin fails++; $display("FAIL flush_then_mul: got %h want %h", {hi_o, lo_o}, 64'h00000007_00000008); end
  endtask

  task automatic test_rst_in_acc;
    load_hilo(64'h00000001_00000001);
    present(3'd4, 64'h5, 32'd0);
    tick();
    idle_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    tests++; if ({hi_o, lo_o} !== 64'd0) begin fails++; $display("FAIL rst_acc_hilo: got %h want 0", {hi_o, lo_o}); end
    tests++; if (stall_req !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rst_acc_ctrl: stall=%b busy=%b want 0 0", stall_req, busy); end
    tick();
    tests++; if ({hi_o, lo_o} !== 64'd0) begin fails++; $display("FAIL rst_acc_nowrite: got %h want 0", {hi_o, lo_o}); end
  endtask

  task automatic test_back_to_back;
    load_hilo(64'h00000000_00000001);
    present(3'd4, 64'd2, 32'd0);
    tick();
    // MUL held by the controller while stalled.
    present(3'd1, 64'hAAAA_AAAA_5555_5555, 32'd0);
    tick();
    tests++; if ({hi_o, lo_o} !== (c_en ? 64'h00000000_00000003 : 64'hAAAA_AAAA_5555_5555)) begin
      fails++; $display("FAIL b2b_acc: got %h want %h", {hi_o, lo_o}, (c_en ? 64'h00000000_00000003 : 64'hAAAA_AAAA_5555_5555)); end
    tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL b2b_stall: got %b want 0", stall_req); end
    tick();
    idle_in();
    tests++; if ({hi_o, lo_o} !== 64'hAAAA_AAAA_5555_5555) begin fails++; $display("FAIL b2b_mul: got %h want %h", {hi_o, lo_o}, 64'hAAAA_AAAA_5555_5555); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mthi_mtlo();
    test_madd();
    test_msub();
    test_flush();
    test_rst_in_acc();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
